// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal slices with one
// register stage per slice, followed by signed saturation, NZVC flags and a valid/ready handshake.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int SW = WIDTH / STAGES;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic ovf(input logic xs, input logic ys, input logic rs);
    return (xs == ys) && (rs != xs);
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] raw, input logic xs,
                                             input logic v, input logic en);
    logic signed [WIDTH-1:0] lim;
    lim = xs ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return (en && v) ? lim : raw;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] yy;

  // Inputs seen by each slice: stage 0 from the ports, stage k from stage k-1 registers.
  logic             vi [STAGES];
  logic             ci [STAGES];
  logic             si [STAGES];
  logic [WIDTH-1:0] xi [STAGES];
  logic [WIDTH-1:0] yi [STAGES];
  logic [WIDTH-1:0] ri [STAGES];
  logic [SW:0]      slice [STAGES];
  logic [WIDTH-1:0] rn [STAGES];
  logic             sc [STAGES];

  logic             vld_p [NR];
  logic             cy_p  [NR];
  logic             sat_p [NR];
  logic [WIDTH-1:0] x_p   [NR];
  logic [WIDTH-1:0] yy_p  [NR];
  logic [WIDTH-1:0] res_p [NR];

  logic [WIDTH-1:0] raw;
  logic             xs_l;
  logic             ys_l;
  logic             v_l;
  logic [WIDTH-1:0] sum_l;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign yy       = sub ? ~y : y;

  assign vi[0] = in_valid;
  assign ci[0] = sub;
  assign si[0] = sat;
  assign xi[0] = x;
  assign yi[0] = yy;
  assign ri[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign vi[k] = vld_p[k-1];
    assign ci[k] = cy_p[k-1];
    assign si[k] = sat_p[k-1];
    assign xi[k] = x_p[k-1];
    assign yi[k] = yy_p[k-1];
    assign ri[k] = res_p[k-1];
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, xi[k][k*SW +: SW]} + {1'b0, yi[k][k*SW +: SW]} + (SW+1)'(ci[k]);
      sc[k]    = slice[k][SW];
      rn[k]    = ri[k];
      rn[k][k*SW +: SW] = slice[k][SW-1:0];
    end
  end

  // Stage boundaries 0..STAGES-2: slice result, slice carry and skewed operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) vld_p[k] <= vi[k];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        cy_p[k]  <= sc[k];
        sat_p[k] <= si[k];
        x_p[k]   <= xi[k];
        yy_p[k]  <= yi[k];
        res_p[k] <= rn[k];
      end
    end
  end

  assign raw   = rn[STAGES-1];
  assign xs_l  = xi[STAGES-1][WIDTH-1];
  assign ys_l  = yi[STAGES-1][WIDTH-1];
  assign v_l   = ovf(xs_l, ys_l, raw[WIDTH-1]);
  assign sum_l = clamp(raw, xs_l, v_l, si[STAGES-1]);

  // Final stage boundary: the output registers, cleared by reset so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (advance) begin
      out_valid <= vi[STAGES-1];
      sum       <= sum_l;
      cout      <= sc[STAGES-1];
      flag_n    <= sum_l[WIDTH-1];
      flag_z    <= (sum_l == '0);
      flag_v    <= v_l;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, STAGES=4): directed steps plus a randomized stream,
// checked against an arithmetic reference model through an in-order scoreboard.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;

  int n_tests = 0;
  int n_fail  = 0;
  int out_cnt = 0;
  logic [19:0] exp_q[$];

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  // Reference: {sum, cout, n, z, v} from integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic st);
    int sa, sb, sr;
    logic [16:0] u;
    logic [15:0] r;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      sr = sa - sb;
      c  = (a >= b);
      r  = a - b;
    end else begin
      sr = sa + sb;
      u  = {1'b0, a} + {1'b0, b};
      c  = u[16];
      r  = u[15:0];
    end
    v = (sr > 32767) || (sr < -32768);
    if (st && v) r = (sr > 0) ? 16'h7FFF : 16'h8000;
    return {r, c, r[15], (r == 16'h0000), v};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom % 6)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop on output transfers, push on input transfers.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else chk("out", 32'({sum, cout, flag_n, flag_z, flag_v}), 32'(exp_q.pop_front()));
        out_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, sub, sat));
    end
  end

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st, input logic [19:0] expv);
    int n;
    int lat;
    in_valid = 1'b1; x = a; y = b; sub = s; sat = st;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk(tag, 32'({sum, cout, flag_n, flag_z, flag_v}), 32'(expv));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int stale;
    int cnt0;
    logic hist [16];
    logic expv;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({sum, cout, flag_n, flag_z, flag_v}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("t1_add",     16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 4'b0000});
    run_one("t2_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 4'b1010});
    run_one("t2_sub",     16'h0005, 16'h0007, 1'b1, 1'b0, {16'hFFFE, 4'b0100});
    run_one("t3_sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b0001});
    run_one("t3_wrap",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0101});
    run_one("t3_sat_neg", 16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 4'b1101});

    // Back-pressure: 8 adds i+i, consumer stalls on cycles 5..7.
    k = 0;
    cnt0 = 0;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (cnt0 < 8) begin
        in_valid = 1'b1; x = 16'(cnt0 + 1); y = 16'(cnt0 + 1); sub = 1'b0; sat = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c >= 5 && c <= 7) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(sum), 32'(exp_q[0][19:4]));
      end
      if (out_valid && out_ready) begin
        chk("bp_seq", 32'(sum), 32'(2 * (k + 1)));
        k++;
      end
      if (in_valid && in_ready) cnt0++;
      @(posedge clk); #1;
    end
    chk("bp_count", 32'(k), 32'd8);
    out_ready = 1'b1;

    // Bubbles: alternate in_valid, out_valid follows 4 cycles later.
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10) && (c % 2 == 0);
      x = rnd16(); y = rnd16(); sub = 1'($urandom & 1); sat = 1'($urandom & 1);
      hist[c] = in_valid;
      expv = (c >= 4) ? hist[c-4] : 1'b0;
      @(negedge clk);
      chk("bubble_vld", 32'(out_valid), 32'(expv));
      @(posedge clk); #1;
    end

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; x = 16'(16'h1000 * (c + 1) + 1); y = 16'h0001; sub = 1'b0; sat = 1'b0;
      @(negedge clk); @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_outputs", 32'({sum, cout, flag_n, flag_z, flag_v}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    stale = 0;
    repeat (10) begin @(negedge clk); if (out_valid) stale++; end
    chk("no_stale", 32'(stale), 32'd0);
    @(posedge clk); #1;

    // Randomized stream with random back-pressure.
    cnt0 = out_cnt;
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom % 4) != 0;
      x = rnd16(); y = rnd16(); sub = 1'($urandom & 1); sat = 1'($urandom & 1);
      out_ready = ($urandom % 4) != 0;
      @(negedge clk); @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) begin @(negedge clk); @(posedge clk); #1; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_progress", 32'(out_cnt > cnt0 + 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined signed/unsigned adder-subtractor. It is the successor to the team's fixed 16-bit ripple adder and serves the PC/ALU datapath. The carry chain is split into STAGES equal slices, with one register stage per slice. The block adds subtraction, signed saturation, NZVC flags and a valid/ready handshake with back-pressure.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of STAGES, and WIDTH >= 4.
- STAGES, 4: number of pipeline stages (carry slices). Must be >= 1. Each slice is WIDTH/STAGES bits wide.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous reset, active-low.
- in_valid, input, 1: the operands and controls on this cycle are valid.
- in_ready, output, 1: the block accepts the input this cycle.
- x, input, WIDTH: operand A.
- y, input, WIDTH: operand B.
- sub, input, 1: 0 gives x+y; 1 gives x-y.
- sat, input, 1: 1 clamps the result on signed overflow.
- out_valid, output, 1: result and flags are valid.
- out_ready, input, 1: the consumer accepts the output this cycle.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of the MSB. For subtraction, 1 means no borrow.
- flag_n, output, 1: sum[WIDTH-1] after saturation.
- flag_z, output, 1: sum equals 0 after saturation.
- flag_v, output, 1: signed overflow of the unclamped result.

Behaviour:
- Reset (rst_n=0, asynchronous): every stage valid bit is 0. out_valid=0, sum=0, cout=0 and all flags are 0. in_ready follows the stall rule below. Asserting reset mid-operation discards every in-flight operation; there is no partial output.
- Stall rule: advance = !(out_valid && !out_ready), and in_ready = advance. The whole pipeline moves together when advance=1 and holds every register when advance=0.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready has no combinational path from in_valid.
- Operand conditioning at entry: yy = sub ? ~y : y, and cin0 = sub.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of x and slice k of yy to the carry registered by stage k-1 (cin0 for stage 0).
  - Registers the slice sum, the slice carry-out and its valid bit.
  - Carries unprocessed upper slices, sat, and the sign bits of x and yy forward in skew registers.
- Latency: an operation accepted on cycle t with no stalls presents out_valid=1 on cycle t+STAGES. Throughput is one operation per cycle.
- Bubbles: a cycle with in_valid=0 and advance=1 inserts a bubble (valid=0). Data registers may update or hold; they are don't-care while valid=0.
- Final-stage outputs:
  - raw = the concatenated slice sums; cout = the final slice carry.
  - v = (xs == yys) && (raw[WIDTH-1] != xs), where xs and yys are the sign bits of x and yy.
  - If sat && v: sum = 0111…1 when xs=0, and 1000…0 when xs=1. Otherwise sum = raw.
  - flag_v = v, regardless of sat.
  - flag_n and flag_z are computed from the post-saturation sum.
  - cout is always computed from raw.
- Outputs are registered: sum, cout and all flags are driven from the last stage registers. They hold stable while out_valid && !out_ready.
- Simultaneous events: with a full pipeline and out_ready=1, an input accept and an output transfer happen in the same cycle.
- Boundary case STAGES=1: a single-cycle registered adder with identical semantics.
- Arithmetic is modulo 2^WIDTH; no other exceptions are raised.

Test Plan:
All cases use WIDTH=16 and STAGES=4.
1. Reset, then x=0x1234, y=0x4321, sub=0, sat=0, accepted on cycle t -> out_valid on cycle t+4 with sum=0x5555, cout=0, N=0, Z=0, V=0.
2. Carry across all slices: x=0xFFFF, y=0x0001, add -> sum=0x0000, cout=1, Z=1, V=0. Then sub with x=0x0005, y=0x0007 -> sum=0xFFFE, cout=0, N=1.
3. Saturation:
   - x=0x7FFF, y=0x0001, add, sat=1 -> sum=0x7FFF, V=1, N=0. Same inputs with sat=0 -> sum=0x8000, V=1, N=1.
   - x=0x8000, y=0x0001, sub, sat=1 -> sum=0x8000, V=1.
4. Back-pressure: stream 8 back-to-back adds (i+i for i=1..8) and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, the output held stable, and all 8 results (2,4,…,16) delivered in order with none lost or duplicated.
5. Bubbles: alternate in_valid=1/0 with out_ready=1 -> out_valid alternates with a 4-cycle offset and the results are correct.
6. Reset mid-stream: assert rst_n=0 asynchronously between clock edges with 3 operations in flight -> outputs clear immediately, and no stale out_valid appears after rst_n is released.
